pulse_stretcher_queue: RTL and testbench

//  Inverse of the level-to-pulse edge detector: turns single-cycle event pulses back into

---
 rtl/pulse_stretcher_queue_pkg.sv | 19 +
 rtl/pulse_stretcher_queue_sat.sv | 46 ++++
 rtl/pulse_stretcher_queue.sv | 132 +++++++++++++
 tb/tb_pulse_stretcher_queue.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_stretcher_queue_pkg.sv
// Shared definitions for the pulse stretcher: state encoding and a small
// constant helper used to size the phase counter.
package pulse_stretcher_queue_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        HIGH = ST_HIGH,
        GAP  = ST_GAP
    } state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulse_stretcher_queue_sat.sv
// Saturating up/down counter holding queued events; flags an increment
// that could not be honoured because the count was already at its maximum.
module sat_updown_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         sat_hit
);

    localparam logic [W-1:0] MAX_CNT = '1;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        sat_hit = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (inc && !dec) begin
            if (count_q == MAX_CNT) begin
                sat_hit = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pulse_stretcher_queue.sv
// Turns single-cycle event strobes into fixed-width high windows separated by
// a guaranteed low gap, queueing events that arrive while a window is running.
module pulse_stretcher_queue
    import pulse_stretcher_queue_pkg::*;
#(
    parameter int HIGH_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int PEND_W      = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pulse_in,
    input  logic              clear,
    output logic              level_out,
    output logic              busy,
    output logic              done,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int PH_W = $clog2(max2(HIGH_CYCLES, GAP_CYCLES) + 1);
    localparam logic [PH_W-1:0] HIGH_LOAD = PH_W'(HIGH_CYCLES - 1);
    localparam logic [PH_W-1:0] GAP_LOAD  = PH_W'(GAP_CYCLES - 1);

    state_e            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              level_q, level_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;

    logic              start;
    logic              phase_last;
    logic              pend_inc;
    logic              pend_dec;
    logic              sat_hit;
    logic [PEND_W-1:0] pend_cnt;

    assign phase_last = (phase_q == '0);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        start   = 1'b0;
        if (clear) begin
            state_d = IDLE;
            phase_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pulse_in) begin
                        state_d = HIGH;
                        phase_d = HIGH_LOAD;
                    end
                end
                HIGH: begin
                    if (phase_last) begin
                        state_d = GAP;
                        phase_d = GAP_LOAD;
                    end else begin
                        phase_d = phase_q - 1'b1;
                    end
                end
                GAP: begin
                    if (phase_last) begin
                        // Back-to-back windows: relaunch straight from the last gap cycle
                        if ((pend_cnt != '0) || pulse_in) begin
                            start   = 1'b1;
                            state_d = HIGH;
                            phase_d = HIGH_LOAD;
                        end else begin
                            state_d = IDLE;
                            phase_d = '0;
                        end
                    end else begin
                        phase_d = phase_q - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    phase_d = '0;
                end
            endcase
        end

        level_d    = (state_d == HIGH);
        busy_d     = (state_d != IDLE);
        done_d     = (state_q == HIGH) && (state_d == GAP);
        overflow_d = clear ? 1'b0 : (overflow_q | sat_hit);
    end

    // A launch that coincides with a new pulse consumes one event and adds one
    assign pend_inc = pulse_in && (state_q != IDLE) && !start && !clear;
    assign pend_dec = start && (pend_cnt != '0) && !pulse_in;

    sat_updown_counter #(
        .W (PEND_W)
    ) u_pending (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (pend_inc),
        .dec     (pend_dec),
        .clr     (clear),
        .count   (pend_cnt),
        .sat_hit (sat_hit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            level_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            level_q    <= level_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign level_out = level_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pending   = pend_cnt;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_pulse_stretcher_queue.sv
// Scoreboard bench for pulse_stretcher_queue: stimulus queues hand-computed
// per-cycle expectations and window start cycles; a monitor checks them.
module tb_pulse_stretcher_queue;

    localparam int HC = 4;
    localparam int GC = 2;
    localparam int PW = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          pulse_in = 1'b0;
    logic          clear = 1'b0;
    logic          level_out;
    logic          busy;
    logic          done;
    logic [PW-1:0] pending;
    logic          overflow;

    pulse_stretcher_queue #(
        .HIGH_CYCLES (HC),
        .GAP_CYCLES  (GC),
        .PEND_W      (PW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pulse_in  (pulse_in),
        .clear     (clear),
        .level_out (level_out),
        .busy      (busy),
        .done      (done),
        .pending   (pending),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int c;
        int kind;
        int val;
    } chk_t;

    chk_t  chk_q[$];
    int    win_q[$];
    int    tests = 0;
    int    fails = 0;
    bit    finishing = 1'b0;

    localparam int K_LVL = 0;
    localparam int K_BSY = 1;
    localparam int K_DON = 2;
    localparam int K_PND = 3;
    localparam int K_OVF = 4;

    function automatic string kname(input int k);
        case (k)
            K_LVL:   return "level_out";
            K_BSY:   return "busy";
            K_DON:   return "done";
            K_PND:   return "pending";
            default: return "overflow";
        endcase
    endfunction

    function automatic int actual(input int k);
        case (k)
            K_LVL:   return int'(level_out);
            K_BSY:   return int'(busy);
            K_DON:   return int'(done);
            K_PND:   return int'(pending);
            default: return int'(overflow);
        endcase
    endfunction

    task automatic expect_rng(input int c0, input int c1, input int k, input int v);
        chk_t e;
        for (int c = c0; c <= c1; c++) begin
            e.c = c;
            e.kind = k;
            e.val = v;
            chk_q.push_back(e);
        end
    endtask

    task automatic expect_at(input int c, input int k, input int v);
        expect_rng(c, c, k, v);
    endtask

    task automatic expect_zero(input int c0, input int c1);
        for (int k = 0; k < 5; k++) expect_rng(c0, c1, k, 0);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold_pulse(input int c0, input int c1);
        goto(c0);
        pulse_in = 1'b1;
        goto(c1 + 1);
        pulse_in = 1'b0;
    endtask

    // Monitor: all comparisons happen here, on the falling edge
    initial begin
        logic prev_level;
        prev_level = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = chk_q.size() - 1; i >= 0; i--) begin
                if (chk_q[i].c == cyc) begin
                    tests++;
                    if (actual(chk_q[i].kind) != chk_q[i].val) begin
                        fails++;
                        $display("FAIL %s @cyc %0d: got %0d, expected %0d",
                                 kname(chk_q[i].kind), cyc, actual(chk_q[i].kind), chk_q[i].val);
                    end
                    chk_q.delete(i);
                end
            end
            if (level_out && !prev_level) begin
                tests++;
                if (win_q.size() == 0) begin
                    fails++;
                    $display("FAIL window_start: unexpected window @cyc %0d, expected none", cyc);
                end else begin
                    if (win_q[0] != cyc) begin
                        fails++;
                        $display("FAIL window_start: got cyc %0d, expected cyc %0d", cyc, win_q[0]);
                    end
                    void'(win_q.pop_front());
                end
            end
            prev_level = level_out;
            if (finishing) begin
                tests++;
                if (chk_q.size() != 0) begin
                    fails++;
                    $display("FAIL leftover_checks: got %0d unchecked, expected 0", chk_q.size());
                end
                tests++;
                if (win_q.size() != 0) begin
                    fails++;
                    $display("FAIL missing_windows: got %0d not seen, expected 0", win_q.size());
                end
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic scen_single(input int b);
        win_q.push_back(b + 11);
        expect_at(b + 10, K_LVL, 0);
        expect_rng(b + 11, b + 14, K_LVL, 1);
        expect_rng(b + 15, b + 17, K_LVL, 0);
        expect_at(b + 14, K_DON, 0);
        expect_at(b + 15, K_DON, 1);
        expect_at(b + 16, K_DON, 0);
        expect_at(b + 10, K_BSY, 0);
        expect_rng(b + 11, b + 16, K_BSY, 1);
        expect_at(b + 17, K_BSY, 0);
        expect_rng(b + 10, b + 17, K_PND, 0);
        hold_pulse(b + 10, b + 10);
        goto(b + 18);
    endtask

    task automatic scen_two(input int b);
        win_q.push_back(b + 11);
        win_q.push_back(b + 17);
        expect_rng(b + 11, b + 14, K_LVL, 1);
        expect_rng(b + 15, b + 16, K_LVL, 0);
        expect_rng(b + 17, b + 20, K_LVL, 1);
        expect_at(b + 21, K_LVL, 0);
        expect_at(b + 11, K_PND, 0);
        expect_rng(b + 12, b + 16, K_PND, 1);
        expect_at(b + 17, K_PND, 0);
        expect_at(b + 15, K_DON, 1);
        expect_at(b + 16, K_DON, 0);
        expect_at(b + 21, K_DON, 1);
        expect_at(b + 16, K_BSY, 1);
        expect_at(b + 23, K_BSY, 0);
        hold_pulse(b + 10, b + 11);
        goto(b + 24);
    endtask

    task automatic scen_last_gap(input int b);
        win_q.push_back(b + 11);
        win_q.push_back(b + 17);
        expect_rng(b + 10, b + 22, K_PND, 0);
        expect_rng(b + 15, b + 16, K_LVL, 0);
        expect_rng(b + 17, b + 20, K_LVL, 1);
        expect_at(b + 21, K_LVL, 0);
        expect_rng(b + 16, b + 17, K_BSY, 1);
        expect_at(b + 23, K_BSY, 0);
        expect_at(b + 15, K_DON, 1);
        expect_at(b + 21, K_DON, 1);
        hold_pulse(b + 10, b + 10);
        hold_pulse(b + 16, b + 16);
        goto(b + 24);
    endtask

    task automatic scen_saturate(input int b);
        for (int k = 0; k < 9; k++) win_q.push_back(b + 11 + 6 * k);
        for (int i = 0; i < 5; i++) expect_at(b + 12 + i, K_PND, 1 + i);
        expect_at(b + 17, K_PND, 5);
        expect_at(b + 18, K_PND, 6);
        expect_rng(b + 19, b + 22, K_PND, 7);
        expect_at(b + 23, K_PND, 6);
        expect_at(b + 58, K_PND, 1);
        expect_at(b + 59, K_PND, 0);
        expect_at(b + 19, K_OVF, 0);
        expect_rng(b + 20, b + 21, K_OVF, 1);
        expect_at(b + 65, K_OVF, 1);
        expect_rng(b + 21, b + 22, K_LVL, 0);
        expect_rng(b + 63, b + 64, K_LVL, 0);
        expect_rng(b + 59, b + 62, K_LVL, 1);
        expect_at(b + 64, K_BSY, 1);
        expect_at(b + 65, K_BSY, 0);
        hold_pulse(b + 10, b + 19);
        goto(b + 66);
    endtask

    task automatic scen_clear(input int b);
        win_q.push_back(b + 11);
        expect_at(b + 13, K_PND, 2);
        expect_at(b + 13, K_OVF, 1);
        expect_at(b + 13, K_LVL, 1);
        expect_at(b + 13, K_BSY, 1);
        expect_zero(b + 14, b + 14);
        expect_rng(b + 15, b + 18, K_BSY, 0);
        expect_rng(b + 15, b + 18, K_PND, 0);
        expect_rng(b + 15, b + 18, K_LVL, 0);
        hold_pulse(b + 10, b + 12);
        pulse_in = 1'b1;
        clear = 1'b1;
        goto(b + 14);
        pulse_in = 1'b0;
        clear = 1'b0;
        goto(b + 20);
    endtask

    task automatic scen_async_reset(input int b);
        win_q.push_back(b + 11);
        expect_rng(b + 12, b + 14, K_PND, 1);
        expect_at(b + 14, K_LVL, 1);
        expect_zero(b + 15, b + 19);
        hold_pulse(b + 10, b + 11);
        goto(b + 15);
        #2;
        reset_n = 1'b0;
        goto(b + 17);
        #2;
        reset_n = 1'b1;
        goto(b + 20);
    endtask

    initial begin
        expect_zero(1, 5);
        goto(3);
        #2;
        reset_n = 1'b1;
        scen_single(10);
        scen_two(30);
        scen_last_gap(60);
        scen_saturate(90);
        scen_clear(160);
        scen_async_reset(185);
        scen_single(210);
        goto(232);
        finishing = 1'b1;
    end

endmodule
